ks10_mem_ctrl: RTL and testbench



---
 rtl/ks10_mem_pkg.sv | 31 +++
 rtl/ks10_mem_lat.sv | 43 ++++
 rtl/ks10_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ks10_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks10_mem_pkg.sv
// ----------------------------------------------------------------------------
// ks10_mem_pkg: shared state encoding, address-word bit positions and defaults.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ks10_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    SWPWR = 3'd3,
    ACK   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // KS10 numbering: bit 0 is the MSB of the 36-bit word.
  localparam int BIT_READ     = 3;
  localparam int BIT_WRITE    = 5;
  localparam int BIT_IO       = 10;
  localparam int ADDR_LSB     = 14;
  localparam int ADDR_FIELD_W = 36 - ADDR_LSB;

  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_MEM_SIZE   = 2 ** 19;
  localparam int DEF_RD_LAT     = 2;

endpackage

`default_nettype wire

// File: rtl/ks10_mem_lat.sv
// ----------------------------------------------------------------------------
// ks10_mem_lat: loadable 2-bit down-counter; done strobes when RD_LAT expires.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ks10_mem_lat #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_M1;
    end else if (en && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  assign done = en && (cnt_q == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ks10_mem_ctrl.sv
// ----------------------------------------------------------------------------
// ks10_mem_ctrl: KS10 main-memory controller (read, write, swap) for 36-bit SRAM.
// Rev 1.0. Define KS10_MEM_NXM_EN to refuse word addresses >= MEM_SIZE.
// ----------------------------------------------------------------------------
`default_nettype none

module ks10_mem_ctrl
  import ks10_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memREQI,
  output logic                  memACKO,
  input  logic [0:35]           busADDRI,
  input  logic [0:35]           busDATAI,
  output logic [0:35]           memDATAO,
  output logic [ADDR_WIDTH-1:0] ssramADDR,
  output logic [0:35]           ssramDOUT,
  input  logic [0:35]           ssramDIN,
  output logic                  ssramCE,
  output logic                  ssramWE
);

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    ce_q, ce_d;
  logic                    we_q, we_d;
  logic                    swap_q, swap_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [0:35]             dout_q, dout_d;
  logic [0:35]             data_q, data_d;

  logic                    w_rd;
  logic                    w_wr;
  logic                    w_io;
  logic                    w_in_range;
  logic                    w_accept;
  logic                    w_lat_load;
  logic                    w_lat_en;
  logic                    w_lat_done;
  logic                    w_unused;
  logic [ADDR_FIELD_W-1:0] w_field;
  logic [ADDR_WIDTH-1:0]   w_addr;

  assign w_rd    = busADDRI[BIT_READ];
  assign w_wr    = busADDRI[BIT_WRITE];
  assign w_io    = busADDRI[BIT_IO];
  assign w_field = busADDRI[ADDR_LSB:35];
  assign w_addr  = w_field[ADDR_WIDTH-1:0];

`ifdef KS10_MEM_NXM_EN
  assign w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH + 1)'(MEM_SIZE));
`else
  assign w_in_range = 1'b1;
`endif

  // Flag bits other than READ/WRITE/IO and high address bits are not decoded.
  assign w_unused = ^{busADDRI, MEM_SIZE[0]};

  assign w_accept = memREQI && !w_io && (w_rd || w_wr) && w_in_range;

  ks10_mem_lat #(
    .RD_LAT (RD_LAT)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (w_lat_load),
    .en   (w_lat_en),
    .done (w_lat_done)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    ce_d       = 1'b0;
    we_d       = 1'b0;
    swap_d     = swap_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    data_d     = data_q;
    w_lat_load = 1'b0;
    w_lat_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          addr_d     = w_addr;
          dout_d     = busDATAI;
          swap_d     = w_rd && w_wr;
          w_lat_load = 1'b1;
          ce_d       = 1'b1;
          if (w_rd) begin
            state_d = RD;
          end else begin
            // Write acks in the same clock the SRAM commits it.
            we_d    = 1'b1;
            ack_d   = 1'b1;
            state_d = WR;
          end
        end
      end
      RD: begin
        w_lat_en = 1'b1;
        if (!memREQI) begin
          state_d = IDLE;
        end else if (w_lat_done) begin
          data_d  = ssramDIN;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          ce_d = 1'b1;
        end
      end
      ACK: begin
        if (swap_q) begin
          ce_d    = 1'b1;
          we_d    = 1'b1;
          state_d = SWPWR;
        end else begin
          state_d = DONE;
        end
      end
      WR, SWPWR: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      swap_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      swap_q  <= swap_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      data_q  <= data_d;
    end
  end

  assign memACKO   = ack_q;
  assign memDATAO  = data_q;
  assign ssramADDR = addr_q;
  assign ssramDOUT = dout_q;
  assign ssramCE   = ce_q;
  assign ssramWE   = we_q;

endmodule

`default_nettype wire

// File: tb/tb_ks10_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ks10_mem_ctrl: directed bench for ks10_mem_ctrl with a 2^18-word SRAM model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ks10_mem_ctrl;
  import ks10_mem_pkg::*;

  localparam int AW  = 19;
  localparam int MSZ = 2 ** 18;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          memREQI;
  logic          memACKO;
  logic [0:35]   busADDRI;
  logic [0:35]   busDATAI;
  logic [0:35]   memDATAO;
  logic [AW-1:0] ssramADDR;
  logic [0:35]   ssramDOUT;
  logic [0:35]   ssramDIN;
  logic          ssramCE;
  logic          ssramWE;

  int vectors    = 0;
  int miscompares = 0;

  ks10_mem_ctrl #(
    .ADDR_WIDTH (AW),
    .MEM_SIZE   (MSZ),
    .RD_LAT     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memREQI   (memREQI),
    .memACKO   (memACKO),
    .busADDRI  (busADDRI),
    .busDATAI  (busDATAI),
    .memDATAO  (memDATAO),
    .ssramADDR (ssramADDR),
    .ssramDOUT (ssramDOUT),
    .ssramDIN  (ssramDIN),
    .ssramCE   (ssramCE),
    .ssramWE   (ssramWE)
  );

  always #5 clk = ~clk;

  // Installed SRAM is 2^18 words, so the top address bit aliases onto the low half.
  logic [35:0] mem [0:MSZ-1];
  logic [35:0] rd_q = '0;
  always @(posedge clk) begin
    if (ssramCE) begin
      if (ssramWE) mem[ssramADDR[17:0]] <= ssramDOUT;
      else         rd_q <= mem[ssramADDR[17:0]];
    end
  end
  assign ssramDIN = rd_q;

  function automatic logic [0:35] aw(input logic rd, input logic wr, input logic io,
                                     input logic [21:0] a);
    logic [0:35] w;
    w        = '0;
    w[3]     = rd;
    w[5]     = wr;
    w[10]    = io;
    w[14:35] = a;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [0:35] a, input logic [35:0] d,
                     output int lat, output logic [35:0] rdata);
    busADDRI = a;
    busDATAI = d;
    memREQI  = 1'b1;
    lat      = 0;
    rdata    = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (memACKO) begin
        lat   = i;
        rdata = memDATAO;
        break;
      end
    end
    memREQI  = 1'b0;
    busADDRI = '0;
    busDATAI = '0;
    repeat (3) step();
  endtask

  task automatic idle_watch(input logic [0:35] a, input int n,
                            output int acks, output int ces, output int notidle);
    acks     = 0;
    ces      = 0;
    notidle  = 0;
    busADDRI = a;
    memREQI  = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (memACKO) acks++;
      if (ssramCE) ces++;
      if (dut.state_q != IDLE) notidle++;
    end
    memREQI  = 1'b0;
    busADDRI = '0;
    step();
  endtask

  initial begin
    int          lat;
    int          acks;
    int          ces;
    int          notidle;
    int          a1;
    int          a2;
    int          nack;
    int          consec;
    logic        prev;
    logic [35:0] rdata;
    logic [35:0] d1;
    logic [35:0] d2;
    logic [35:0] exp_last;

    rst      = 1'b1;
    memREQI  = 1'b0;
    busADDRI = '0;
    busDATAI = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   64'(memACKO),   64'd0);
    check("rst_data",  64'(memDATAO),  64'd0);
    check("rst_ce",    64'(ssramCE),   64'd0);
    check("rst_we",    64'(ssramWE),   64'd0);
    check("rst_addr",  64'(ssramADDR), 64'd0);
    check("rst_dout",  64'(ssramDOUT), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;
    step();

    req(aw(0, 1, 0, 22'o0), 36'o777000111222, lat, rdata);
    check("pre0_lat", 64'(lat), 64'd1);
    req(aw(0, 1, 0, 22'o5), 36'o1, lat, rdata);
    check("pre5_lat", 64'(lat), 64'd1);
    req(aw(0, 1, 0, 22'o7), 36'o0, lat, rdata);

    // Write 0o1000: ack, WE and address all visible in clock T0+1.
    busADDRI = aw(0, 1, 0, 22'o1000);
    busDATAI = 36'o123456701234;
    memREQI  = 1'b1;
    step();
    check("wr_ack",  64'(memACKO),   64'd1);
    check("wr_we",   64'(ssramWE),   64'd1);
    check("wr_ce",   64'(ssramCE),   64'd1);
    check("wr_addr", 64'(ssramADDR), 64'o1000);
    check("wr_dout", 64'(ssramDOUT), 64'o123456701234);
    memREQI = 1'b0;
    step();
    check("wr_ack_once", 64'(memACKO), 64'd0);
    check("wr_commit",   64'(mem[18'o1000]), 64'o123456701234);
    repeat (2) step();

    req(aw(1, 0, 0, 22'o1000), 36'o0, lat, rdata);
    check("rd_lat",  64'(lat),   64'd3);
    check("rd_data", 64'(rdata), 64'o123456701234);

    req(aw(1, 1, 0, 22'o5), 36'o2, lat, rdata);
    check("swap_lat",  64'(lat),   64'd3);
    check("swap_data", 64'(rdata), 64'o1);
    req(aw(1, 0, 0, 22'o5), 36'o0, lat, rdata);
    check("swap_rb_lat",  64'(lat),   64'd3);
    check("swap_rb_data", 64'(rdata), 64'o2);

    idle_watch(aw(1, 0, 1, 22'o5), 20, acks, ces, notidle);
    check("io_acks",    64'(acks),    64'd0);
    check("io_ce",      64'(ces),     64'd0);
    check("io_notidle", 64'(notidle), 64'd0);
    idle_watch(aw(0, 0, 0, 22'o5), 20, acks, ces, notidle);
    check("noflag_acks",    64'(acks),    64'd0);
    check("noflag_ce",      64'(ces),     64'd0);
    check("noflag_notidle", 64'(notidle), 64'd0);

`ifdef KS10_MEM_NXM_EN
    idle_watch(aw(1, 0, 0, 22'o1000000), 20, acks, ces, notidle);
    check("nxm_acks", 64'(acks), 64'd0);
    check("nxm_ce",   64'(ces),  64'd0);
    exp_last = 36'o2;
`else
    req(aw(1, 0, 0, 22'o1000000), 36'o0, lat, rdata);
    check("wrap_lat",  64'(lat),   64'd3);
    check("wrap_data", 64'(rdata), 64'o777000111222);
    exp_last = 36'o777000111222;
`endif

    // Abort: request drops one clock into RD.
    busADDRI = aw(1, 0, 0, 22'o1000);
    memREQI  = 1'b1;
    step();
    check("abort_in_rd", 64'(dut.state_q), 64'(RD));
    memREQI = 1'b0;
    step();
    check("abort_idle", 64'(dut.state_q), 64'(IDLE));
    check("abort_ack",  64'(memACKO),     64'd0);
    acks = 0;
    repeat (5) begin
      step();
      if (memACKO) acks++;
    end
    check("abort_noack", 64'(acks),     64'd0);
    check("abort_hold",  64'(memDATAO), 64'(exp_last));

    // Reset asserted mid-WR.
    busADDRI = aw(0, 1, 0, 22'o7);
    busDATAI = 36'o555;
    memREQI  = 1'b1;
    step();
    check("rstwr_we_pre", 64'(ssramWE), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstwr_we",   64'(ssramWE),  64'd0);
    check("rstwr_ack",  64'(memACKO),  64'd0);
    check("rstwr_data", 64'(memDATAO), 64'd0);
    memREQI  = 1'b0;
    busADDRI = '0;
    busDATAI = '0;
    step();
    check("rstwr_nowrite", 64'(mem[18'o7]), 64'd0);
    rst = 1'b0;
    step();
    req(aw(1, 0, 0, 22'o7), 36'o0, lat, rdata);
    check("rstwr_rb_lat",  64'(lat),   64'd3);
    check("rstwr_rb_data", 64'(rdata), 64'd0);

    // Back-to-back reads with memREQI held high.
    a1 = 0; a2 = 0; nack = 0; consec = 0; prev = 1'b0; d1 = '0; d2 = '0;
    busADDRI = aw(1, 0, 0, 22'o1000);
    memREQI  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (memACKO && prev) consec++;
      prev = memACKO;
      if (memACKO) begin
        nack++;
        if (nack == 1) begin
          a1       = i;
          d1       = memDATAO;
          busADDRI = aw(1, 0, 0, 22'o5);
        end else if (nack == 2) begin
          a2      = i;
          d2      = memDATAO;
          memREQI = 1'b0;
        end
      end
    end
    check("b2b_nack",   64'(nack),   64'd2);
    check("b2b_a1",     64'(a1),     64'd3);
    check("b2b_a2",     64'(a2),     64'd8);
    check("b2b_d1",     64'(d1),     64'o123456701234);
    check("b2b_d2",     64'(d2),     64'o2);
    check("b2b_consec", 64'(consec), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
